// File: rtl/ncore_psum_norm_pkg.sv
`default_nettype none
// ============================================================================
// Package : norm_pkg
// Brief   : Shared types and sizing helpers for the N-channel psum normalizer.
// Rev     : 1.0  initial release
// ============================================================================
package norm_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIV     = 2'd1,
    OUT     = 2'd2
  } norm_state_t;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of elements held per frame.
  function automatic int elem_cnt(input int nch, input int col);
    return nch * col;
  endfunction

  // Accumulator width that holds |-2^(bw-1)| summed over every element.
  function automatic int sum_w(input int bw, input int nch, input int col);
    return bw + $clog2(nch * col);
  endfunction

  // Magnitude of a sign-extended element.
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ncore_psum_norm_serial_div.sv
`default_nettype none
// ============================================================================
// Module  : norm_serial_div
// Brief   : Restoring serial divider, one quotient bit per cycle, F+1 bits.
//           done is a level that rises one cycle after the final iteration
//           and holds (with the quotient) until the next start.
// Rev     : 1.0  initial release
// ============================================================================
module norm_serial_div #(
  parameter int SUM_W = 15,
  parameter int F     = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [SUM_W+F-1:0] i_dividend,
  input  logic [SUM_W-1:0]   i_divisor,
  output logic               o_done,
  output logic [F:0]         o_quot
);

  localparam int CW = $clog2(F + 2);

  logic [SUM_W-1:0] r_rem;
  logic [SUM_W-1:0] r_dvs;
  logic [F:0]       r_lo;
  logic [F:0]       r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [SUM_W:0]   w_sh;
  logic [SUM_W:0]   w_sub;
  logic             w_ge;

  // The partial remainder always stays below the divisor, so the trial
  // difference fits SUM_W+1 bits and its MSB is the borrow.
  assign w_sh  = {r_rem, r_lo[F]};
  assign w_sub = w_sh - {1'b0, r_dvs};
  assign w_ge  = ~w_sub[SUM_W];

  // Load operands on start, then shift in one dividend bit per cycle.
  // The high dividend bits seed the remainder; they are below the divisor
  // whenever |p| <= S, so only F+1 quotient bits are needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_lo   <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_rem  <= {1'b0, i_dividend[SUM_W+F-1:F+1]};
      r_lo   <= i_dividend[F:0];
      r_dvs  <= i_divisor;
      r_q    <= '0;
      r_cnt  <= CW'(F + 1);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_sub[SUM_W-1:0] : w_sh[SUM_W-1:0];
      r_q   <= {r_q[F-1:0], w_ge};
      r_lo  <= {r_lo[F-1:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_q;

endmodule
`default_nettype wire

// File: rtl/ncore_psum_norm.sv
`default_nettype none
// ============================================================================
// Module  : ncore_psum_norm
// Brief   : Collects one signed psum vector per channel, sums |psum| over the
//           frame, then streams |p|/S per element as a fixed-point fraction.
//           Define NORM_SIGN_EN for a signed output (sign re-applied,
//           W_OUT-1 fraction bits); default is an unsigned W_OUT-bit fraction.
// Rev     : 1.0  initial release
// ============================================================================
module ncore_psum_norm
  import norm_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int COL     = 8,
  parameter int BW_PSUM = 11,
  parameter int W_OUT   = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCH-1:0]               s_valid,
  output logic [NCH-1:0]               s_ready,
  input  logic [NCH*COL*BW_PSUM-1:0]   psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W_OUT-1:0]             out_data,
  output logic [clog2_min1(NCH)-1:0]   out_ch,
  output logic [clog2_min1(COL)-1:0]   out_idx,
  output logic                         frame_done
);

  localparam int ELEM_CNT = elem_cnt(NCH, COL);
  localparam int SUM_W    = sum_w(BW_PSUM, NCH, COL);
  localparam int CHW      = clog2_min1(NCH);
  localparam int IDXW     = clog2_min1(COL);
  localparam int KW       = clog2_min1(ELEM_CNT);
`ifdef NORM_SIGN_EN
  localparam int F = W_OUT - 1;
`else
  localparam int F = W_OUT;
`endif

  norm_state_t                r_state, w_next_state;
  logic [NCH-1:0]             r_mask, w_mask_next, w_cap, r_s_ready;
  logic [SUM_W-1:0]           r_sum, w_cap_sum;
  logic [NCH*COL*BW_PSUM-1:0] r_vec;
  logic [KW-1:0]              r_k;
  logic [CHW-1:0]             r_ch;
  logic [IDXW-1:0]            r_idx;
  logic                       r_start, r_frame_done;
  logic                       w_last, w_s_zero, w_res_valid, w_out_valid, w_accept;
  logic                       w_div_start, w_div_done;
  logic signed [BW_PSUM-1:0]  w_elem;
  logic [BW_PSUM-1:0]         w_abs;
  logic [F:0]                 w_quot;
  logic [F-1:0]               w_mag;
  logic [W_OUT-1:0]           w_fmt;

  assign w_cap       = s_valid & r_s_ready;
  assign w_s_zero    = (r_sum == '0);
  assign w_last      = (r_k == KW'(ELEM_CNT - 1));
  assign w_res_valid = (r_state == DIV) && !r_start && (w_s_zero || w_div_done);
  assign w_div_start = (r_state == DIV) && r_start && !w_s_zero;
  assign w_elem      = r_vec[r_k*BW_PSUM +: BW_PSUM];
  assign w_abs       = BW_PSUM'(abs32(32'(w_elem)));

  // Magnitude sum of every channel vector captured this cycle.
  always_comb begin
    w_cap_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j < COL; j++) begin
        if (w_cap[c]) begin
          w_cap_sum = w_cap_sum +
            SUM_W'(abs32(32'(signed'(psum_in[(c*COL+j)*BW_PSUM +: BW_PSUM]))));
        end
      end
    end
  end

  // Next state, next capture mask and output handshake.
  always_comb begin
    w_next_state = r_state;
    w_mask_next  = r_mask;
    w_out_valid  = 1'b0;
    case (r_state)
      COLLECT: begin
        w_mask_next = r_mask | w_cap;
        if (&w_mask_next) w_next_state = DIV;
      end
      DIV: begin
        w_out_valid = w_res_valid;
        if (w_res_valid && !out_ready) w_next_state = OUT;
      end
      OUT:     w_out_valid = 1'b1;
      default: w_next_state = COLLECT;
    endcase
    w_accept = w_out_valid && out_ready;
    if (w_accept) begin
      if (w_last) begin
        w_next_state = COLLECT;
        w_mask_next  = '0;
      end else begin
        w_next_state = DIV;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_next_state;
  end

  // Frame datapath: vector capture, running sum, element walk, pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask       <= '0;
      r_s_ready    <= '0;
      r_sum        <= '0;
      r_vec        <= '0;
      r_k          <= '0;
      r_ch         <= '0;
      r_idx        <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_mask       <= w_mask_next;
      r_s_ready    <= (w_next_state == COLLECT) ? ~w_mask_next : '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_state == COLLECT) begin
        r_sum <= r_sum + w_cap_sum;
        for (int c = 0; c < NCH; c++) begin
          if (w_cap[c]) begin
            r_vec[c*COL*BW_PSUM +: COL*BW_PSUM] <= psum_in[c*COL*BW_PSUM +: COL*BW_PSUM];
          end
        end
        if (w_next_state == DIV) r_start <= 1'b1;
      end
      if (w_accept) begin
        if (w_last) begin
          r_k          <= '0;
          r_ch         <= '0;
          r_idx        <= '0;
          r_sum        <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_start <= 1'b1;
          r_k     <= r_k + KW'(1);
          if (r_idx == IDXW'(COL - 1)) begin
            r_idx <= '0;
            r_ch  <= r_ch + CHW'(1);
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
      end
    end
  end

  norm_serial_div #(
    .SUM_W(SUM_W),
    .F    (F)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_div_start),
    .i_dividend({SUM_W'(w_abs), {F{1'b0}}}),
    .i_divisor (r_sum),
    .o_done    (w_div_done),
    .o_quot    (w_quot)
  );

  // A quotient of exactly 2^F only occurs when |p| == S; clamp it.
  assign w_mag = w_quot[F] ? '1 : w_quot[F-1:0];

`ifdef NORM_SIGN_EN
  assign w_fmt = w_elem[BW_PSUM-1] ? (~{1'b0, w_mag} + W_OUT'(1)) : {1'b0, w_mag};
`else
  assign w_fmt = w_mag;
`endif

  assign s_ready    = r_s_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = (w_out_valid && !w_s_zero) ? w_fmt : '0;
  assign out_ch     = r_ch;
  assign out_idx    = r_idx;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ncore_psum_norm.sv
`default_nettype none
// ============================================================================
// Module  : tb_ncore_psum_norm
// Brief   : Directed table-driven bench for ncore_psum_norm with
//           NCH=2, COL=2, BW_PSUM=8, W_OUT=8 (both NORM_SIGN_EN builds).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ncore_psum_norm;

`ifdef NORM_SIGN_EN
  localparam bit SGN = 1'b1;
  localparam int LAT = 8 - 1 + 2;
`else
  localparam bit SGN = 1'b0;
  localparam int LAT = 8 + 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  s_valid = '0;
  logic [1:0]  s_ready;
  logic [31:0] psum_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [0:0]  out_ch;
  logic [0:0]  out_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] psum;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  ncore_psum_norm #(
    .NCH(2), .COL(2), .BW_PSUM(8), .W_OUT(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_idx   (out_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Walk n_el elements: latency from previous event, data, channel/index,
  // optional 5-cycle backpressure hold on element bp_k.
  task automatic run_out(input logic [31:0] exp, input int lat, input int n_el, input int bp_k);
    int n;
    for (int k = 0; k < n_el; k++) begin
      n = 0;
      do begin
        step();
        s_valid = '0;
        n++;
      end while (!out_valid && n < 200);
      chk("latency", n, 1 + lat);
      chk("out_data", out_data, exp[k*8 +: 8]);
      chk("out_ch_idx", {out_ch, out_idx}, k[1:0]);
      chk("s_ready_busy", s_ready, 0);
      if (k == bp_k) begin
        out_ready = 1'b0;
        repeat (5) begin
          step();
          chk("bp_hold", {out_valid, out_data, out_ch, out_idx}, {1'b1, exp[k*8 +: 8], k[1:0]});
        end
        out_ready = 1'b1;
      end
    end
  endtask

  task automatic frame_end();
    step();
    chk("frame_done", frame_done, 1);
    chk("s_ready_at_done", s_ready, 2'b11);
    chk("valid_after_last", out_valid, 0);
    step();
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    tbl[0] = '{32'h0400FF03, SGN ? 32'h4000F030 : 32'h80002060, LAT};
    tbl[1] = '{32'h00000000, 32'h00000000, 1};
    tbl[2] = '{32'h00000080, SGN ? 32'h00000081 : 32'h000000FF, LAT};
    tbl[3] = '{32'h80808080, SGN ? 32'hE0E0E0E0 : 32'h40404040, LAT};
    tbl[4] = '{32'h04030201, SGN ? 32'h3326190C : 32'h664C3319, LAT};
    tbl[5] = '{32'h0000F907, SGN ? 32'h0000C040 : 32'h00008080, LAT};

    step();
    step();
    chk("reset_outputs", {s_ready, out_valid, out_data, out_ch, out_idx, frame_done}, 0);
    reset = 1'b0;
    step();
    chk("s_ready_after_reset", s_ready, 2'b11);

    // Table frames: both channels captured in the same cycle.
    for (int i = 0; i < 6; i++) begin
      chk("s_ready_idle", s_ready, 2'b11);
      psum_in = tbl[i].psum;
      s_valid = 2'b11;
      run_out(tbl[i].exp, tbl[i].lat, 4, -1);
      frame_end();
    end

    // Staggered capture: ch1 first, repeat ignored, ch0 three cycles later.
    psum_in = 32'h00000000;
    s_valid = 2'b10;
    step();
    chk("s_ready_after_ch1", s_ready, 2'b01);
    psum_in = 32'h09090000;
    s_valid = 2'b10;
    step();
    s_valid = '0;
    chk("repeat_ignored", {s_ready, out_valid}, 3'b010);
    step();
    psum_in = 32'h09090005;
    s_valid = 2'b01;
    run_out(SGN ? 32'h0000007F : 32'h000000FF, LAT, 4, -1);
    frame_end();

    // Backpressure on element 1.
    psum_in = tbl[0].psum;
    s_valid = 2'b11;
    run_out(tbl[0].exp, LAT, 4, 1);
    frame_end();

    // Reset in the middle of element 2's division.
    psum_in = tbl[0].psum;
    s_valid = 2'b11;
    run_out(tbl[0].exp, LAT, 2, -1);
    step();
    step();
    step();
    chk("mid_div_no_valid", out_valid, 0);
    reset = 1'b1;
    #1;
    chk("reset_mid", {s_ready, out_valid, out_data, out_ch, out_idx, frame_done}, 0);
    step();
    reset = 1'b0;
    step();
    chk("after_mid_reset", {s_ready, out_valid, frame_done}, 4'b1100);
    psum_in = tbl[4].psum;
    s_valid = 2'b11;
    run_out(tbl[4].exp, LAT, 4, -1);
    frame_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ncore_psum_norm.md
Name: ncore_psum_norm

Overview:
- Single-clock, N-channel successor to the two-core psum normalizer.
- Each core channel hands over one psum vector of COL signed elements per frame.
- Once all NCH vectors are held, the block forms S = sum of |psum| over all NCH*COL elements.
- It then streams each element's normalized magnitude |p|/S as a fixed-point fraction, one element at a time, over a valid/ready output.

Parameters:
- NCH, 2, number of core channels.
- COL, 8, elements per channel vector.
- BW_PSUM, 11, signed psum element width.
- W_OUT, 11, output word width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  NCH  per-channel vector valid.
- s_ready  out  NCH  per-channel vector ready.
- psum_in  in  NCH*COL*BW_PSUM  channel c, element j at bits [(c*COL+j)*BW_PSUM +: BW_PSUM], two's complement.
- out_valid  out  1  normalized element valid.
- out_ready  in  1  downstream accept.
- out_data  out  W_OUT  normalized element.
- out_ch  out  clog2(NCH) (min 1)  channel of out_data.
- out_idx  out  clog2(COL) (min 1)  element index of out_data.
- frame_done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset values: s_ready=0, out_valid=0, out_data=0, out_ch=0, out_idx=0, frame_done=0, state=COLLECT, captured mask=0, S=0.
- In the first cycle after reset deassertion, s_ready = all ones.
- Widths: SUM_W = BW_PSUM + clog2(NCH*COL); this holds the worst case |-2^(BW_PSUM-1)| summed over all elements. F = W_OUT fractional bits.
- State COLLECT:
  - s_ready[c] = 1 while channel c is not yet captured.
  - Capture on s_valid[c] & s_ready[c]; store the vector and add the sum of its COL |elements| into S.
  - Several channels may capture in the same cycle; all their sums are added that cycle.
  - A channel already captured is ignored (s_ready[c]=0) until the frame ends.
  - When the mask becomes full, the next state is DIV with element k=0.
- State DIV, element order k = c*COL + j (channel 0 first, j ascending):
  - Element start cycle: load the dividend |p|<<F.
  - Restoring serial division by S runs for F+1 iterations, one bit per cycle.
  - out_valid rises F+2 cycles after element start. Truncating (floor) division.
  - Quotient 2^F (only possible when |p| = S) saturates to 2^F-1.
  - S = 0: skip the divider; out_valid rises 1 cycle after element start with out_data = 0.
- State OUT:
  - out_valid, out_data, out_ch and out_idx stay stable until out_valid & out_ready.
  - On acceptance, out_valid drops next cycle and element k+1 starts that same next cycle.
  - Acceptance of the last element pulses frame_done next cycle, clears the mask and S, and returns to COLLECT.
  - s_ready reasserts in that frame_done cycle.
- Inputs arriving during DIV/OUT are not accepted (s_ready=0).
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded with no output or frame_done.

Optional Feature:
- Macro NORM_SIGN_EN.
- Defined:
  - F = W_OUT-1.
  - The quotient is negated (two's complement) when the element is negative.
  - Saturation magnitude is 2^(W_OUT-1)-1, applied before negation.
- Undefined:
  - F = W_OUT.
  - out_data is an unsigned magnitude; the sign is discarded.

Decomposition:
- Package norm_pkg holds:
  - SUM_W and ELEM_CNT = NCH*COL, expressed as functions of parameters.
  - The state enum COLLECT/DIV/OUT.
  - An abs helper function.
- One sub-module norm_serial_div:
  - Operands: SUM_W-bit divisor, (SUM_W+F)-bit dividend, F+1 quotient bits.
  - Interface: start/done, with done one cycle after the final iteration.

Test Plan (NCH=2, COL=2, BW_PSUM=8, W_OUT=8):
- Basic frame: ch0 = {3,-1}, ch1 = {0,4} captured the same cycle, S = 8, out_ready = 1 → out_data 96, 32, 0, 128 with (ch,idx) = (0,0),(0,1),(1,0),(1,1); each out_valid 10 cycles after element start; then frame_done.
- Same vectors with NORM_SIGN_EN → 48, 0xF0, 0, 64.
- Staggered capture and saturation:
  - ch1 = {0,0} first, then ch0 = {5,0} three cycles later.
  - s_ready[1] = 0 after capture; a repeated s_valid[1] is ignored.
  - S = 5 → 255, 0, 0, 0 (signed build: 127, 0, 0, 0).
- All-zero frame → four outputs of 0, each out_valid 1 cycle after element start; frame_done; s_ready = 11 in that cycle.
- Backpressure: out_ready low for 5 cycles on element 1 → out_valid, out_data, out_ch, out_idx stable for all 5 cycles; no element skipped.
- Reset mid-DIV on element 2 → all outputs 0 and s_ready = 11 right after reset deasserts; the next full frame produces correct values.
